// File: rtl/game_sched.sv
// Match scheduler for a paddle game: divides clk into game ticks, sequences serve/play/pause/over,
// and issues one-cycle step strobes to the physics step block while in play.
module game_sched #(
  parameter int unsigned TICK_DIV    = 1666667,
  parameter int unsigned SERVE_TICKS = 120,
  parameter int unsigned WIN_SCORE   = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic [4:0]  l_score,
  input  logic [4:0]  r_score,
  output logic        stclk,
  output logic        step_rst,
  output logic [2:0]  state,
  output logic [1:0]  winner,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPause = 3'd3,
    StOver  = 3'd4
  } state_e;

  localparam logic [23:0] TickLast  = 24'(TICK_DIV - 1);
  localparam logic [7:0]  ServeLast = 8'(SERVE_TICKS - 1);
  localparam logic [4:0]  WinScore  = 5'(WIN_SCORE);

  state_e      state_q, state_d;
  logic [23:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]  serve_cnt_q, serve_cnt_d;
  logic [5:0]  prev_sum_q, score_sum;
  logic [1:0]  winner_q, winner_d, win_hit;
  logic        stclk_q, stclk_d;
  logic        step_rst_q;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        tick;

  assign tick      = (tick_cnt_q == TickLast);
  assign score_sum = {1'b0, l_score} + {1'b0, r_score};
  // Bit 0 flags the left side, bit 1 the right side.
  assign win_hit   = {r_score >= WinScore, l_score >= WinScore};

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StServe;
      end
      StServe: begin
        if (start) state_d = StIdle;
        else if (tick && (serve_cnt_q == ServeLast)) state_d = StPlay;
      end
      StPlay: begin
        if (win_hit != 2'b00) begin
          state_d  = StOver;
          winner_d = win_hit;
        end else if (score_sum != prev_sum_q) begin
          state_d = StServe;
        end else if (pause) begin
          state_d = StPause;
        end else if (start) begin
          state_d = StIdle;
        end
      end
      StPause: begin
        if (start) state_d = StIdle;
        else if (pause) state_d = StPlay;
      end
      StOver: begin
        if (start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StIdle) winner_d = 2'b00;
  end

  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    serve_cnt_d = serve_cnt_q;
    if ((state_d == StServe) && (state_q != StServe)) begin
      tick_cnt_d  = '0;
      serve_cnt_d = '0;
    end else if ((state_q == StServe) || (state_q == StPlay)) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 24'd1;
      if ((state_q == StServe) && tick) serve_cnt_d = serve_cnt_q + 8'd1;
    end else if (state_q != StPause) begin
      tick_cnt_d = '0;
    end
  end

  // The tick phase survives a pause, so strobes stay at least TICK_DIV cycles apart.
  assign stclk_d     = (state_q == StPlay) && tick;
  assign frame_cnt_d = (state_d == StIdle) ? 16'd0 : frame_cnt_q + {15'd0, stclk_d};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      serve_cnt_q <= '0;
      prev_sum_q  <= '0;
      winner_q    <= 2'b00;
      stclk_q     <= 1'b0;
      step_rst_q  <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      serve_cnt_q <= serve_cnt_d;
      prev_sum_q  <= score_sum;
      winner_q    <= winner_d;
      stclk_q     <= stclk_d;
      step_rst_q  <= (state_q == StIdle);
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign stclk     = stclk_q;
  assign step_rst  = step_rst_q;
  assign state     = state_q;
  assign winner    = winner_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_game_sched.sv
// Bench for game_sched with TICK_DIV=8, SERVE_TICKS=2, WIN_SCORE=3: a per-cycle vector table fed
// through a scoreboard queue, plus hand-written asynchronous reset sequences.
module tb_game_sched;

  localparam logic [2:0] SI = 3'd0, SS = 3'd1, SP = 3'd2, SPa = 3'd3, SO = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n, start, pause;
  logic [4:0]  l_score, r_score;
  logic        stclk, step_rst;
  logic [2:0]  state;
  logic [1:0]  winner;
  logic [15:0] frame_cnt;

  game_sched #(
    .TICK_DIV(8),
    .SERVE_TICKS(2),
    .WIN_SCORE(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .pause(pause),
    .l_score(l_score),
    .r_score(r_score),
    .stclk(stclk),
    .step_rst(step_rst),
    .state(state),
    .winner(winner),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s, p;
    logic [4:0]  l, r;
    logic [2:0]  st;
    logic        sc, sr;
    logic [1:0]  w;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // step_rst follows the state of the previous cycle, so derive it from the prior record.
  function automatic void add(logic s, logic p, logic [4:0] l, logic [4:0] r, logic [2:0] st,
                              logic sc, logic [1:0] w, logic [15:0] fc);
    vec_t v;
    v.s = s; v.p = p; v.l = l; v.r = r; v.st = st; v.sc = sc; v.w = w; v.fc = fc;
    v.sr = (tbl.size() == 0) ? 1'b1 : (tbl[tbl.size()-1].st == SI);
    tbl.push_back(v);
  endfunction

  function automatic vec_t idle_vec();
    vec_t v;
    v.s = 1'b0; v.p = 1'b0; v.l = 5'd0; v.r = 5'd0;
    v.st = SI; v.sc = 1'b0; v.sr = 1'b1; v.w = 2'b00; v.fc = 16'd0;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [15:0] act, logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @vec %0d: got %0h, want %0h (t=%0t)", nm, idx, act, want, $time);
    end
  endtask

  task automatic check_all(int idx, vec_t e);
    chk("state", idx, {13'd0, state}, {13'd0, e.st});
    chk("stclk", idx, {15'd0, stclk}, {15'd0, e.sc});
    chk("step_rst", idx, {15'd0, step_rst}, {15'd0, e.sr});
    chk("winner", idx, {14'd0, winner}, {14'd0, e.w});
    chk("frame_cnt", idx, frame_cnt, e.fc);
  endtask

  initial begin
    vec_t e;

    // Start -> 16 cycles SERVE -> PLAY; first strobe 8 edges into PLAY, then every 8.
    for (int k = 0; k < 40; k++)
      add(k == 0, 1'b0, 5'd0, 5'd0, (k < 16) ? SS : SP, (k >= 24) && ((k - 24) % 8 == 0),
          2'b00, (k < 24) ? 16'd0 : 16'((k - 24) / 8 + 1));
    add(1'b0, 1'b0, 5'd0, 5'd0, SP, 1'b1, 2'b00, 16'd3);
    for (int j = 0; j < 3; j++) add(1'b0, 1'b0, 5'd0, 5'd0, SP, 1'b0, 2'b00, 16'd3);
    // Pause 4 cycles into the tick period; a score change while paused must not cause a serve.
    add(1'b0, 1'b1, 5'd0, 5'd0, SPa, 1'b0, 2'b00, 16'd3);
    for (int j = 0; j < 16; j++)
      add(1'b0, 1'b0, (j >= 5) ? 5'd1 : 5'd0, 5'd0, SPa, 1'b0, 2'b00, 16'd3);
    for (int j = 0; j < 13; j++)
      add(1'b0, j == 0, 5'd1, 5'd0, SP, (j == 4) || (j == 12), 2'b00,
          16'(3 + int'(j >= 4) + int'(j >= 12)));
    // Point scored: back to SERVE for 16 cycles, no strobe until 8 edges into PLAY.
    for (int j = 0; j < 25; j++)
      add(1'b0, 1'b0, 5'd1, 5'd1, (j < 16) ? SS : SP, j == 24, 2'b00, 16'(5 + int'(j == 24)));
    // Both reach WIN_SCORE together; pause in OVER is ignored; start clears winner.
    add(1'b0, 1'b0, 5'd3, 5'd3, SO, 1'b0, 2'b11, 16'd6);
    for (int j = 0; j < 10; j++) add(1'b0, j == 4, 5'd3, 5'd3, SO, 1'b0, 2'b11, 16'd6);
    add(1'b1, 1'b0, 5'd3, 5'd3, SI, 1'b0, 2'b00, 16'd0);
    add(1'b0, 1'b0, 5'd0, 5'd0, SI, 1'b0, 2'b00, 16'd0);
    add(1'b0, 1'b1, 5'd0, 5'd0, SI, 1'b0, 2'b00, 16'd0);
    // Start+pause: PLAY takes pause, PAUSE takes start; start in SERVE aborts.
    for (int j = 0; j < 17; j++)
      add(j == 0, 1'b0, 5'd0, 5'd0, (j < 16) ? SS : SP, 1'b0, 2'b00, 16'd0);
    add(1'b1, 1'b1, 5'd0, 5'd0, SPa, 1'b0, 2'b00, 16'd0);
    add(1'b0, 1'b0, 5'd0, 5'd0, SPa, 1'b0, 2'b00, 16'd0);
    add(1'b1, 1'b1, 5'd0, 5'd0, SI, 1'b0, 2'b00, 16'd0);
    add(1'b0, 1'b0, 5'd0, 5'd0, SI, 1'b0, 2'b00, 16'd0);
    add(1'b1, 1'b0, 5'd0, 5'd0, SS, 1'b0, 2'b00, 16'd0);
    add(1'b1, 1'b0, 5'd0, 5'd0, SI, 1'b0, 2'b00, 16'd0);
    add(1'b0, 1'b0, 5'd0, 5'd0, SI, 1'b0, 2'b00, 16'd0);
    // IDLE takes start over pause; run until the first strobe is high.
    for (int j = 0; j < 25; j++)
      add(j == 0, j == 0, 5'd0, 5'd0, (j < 16) ? SS : SP, j == 24, 2'b00, 16'(int'(j == 24)));

    rst_n = 1'b1; start = 1'b0; pause = 1'b0; l_score = 5'd0; r_score = 5'd0;
    #1;
    check_all(1000, idle_vec());  // before any clock edge
    repeat (2) @(negedge clk);
    rst_n = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      start = tbl[i].s; pause = tbl[i].p; l_score = tbl[i].l; r_score = tbl[i].r;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_all(i, e);
    end

    // Strobe is high here; reset between clock edges must drop it at once.
    #2 rst_n = 1'b1;
    #1;
    check_all(2000, idle_vec());
    @(posedge clk);
    #1;
    check_all(2001, idle_vec());
    @(negedge clk);
    start = 1'b0; pause = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check_all(3000 + i, idle_vec());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
